// File: rtl/addsub_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_seq_if
//  Purpose  : Bundles the operation request and result signals of
//             addsub_seq so the requester and the datapath share a single
//             port connection.
//  Ports    : master - drives start, m, sat, a, b; receives busy, done,
//                      s, c, o, z
//             slave  - the reverse view, used by the adder/subtractor
//  Revision : 1.0 - initial release
// ============================================================================
interface addsub_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             m;
    logic             sat;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
    logic             z;

    modport master (
        output start, m, sat, a, b,
        input  busy, done, s, c, o, z
    );

    modport slave (
        input  start, m, sat, a, b,
        output busy, done, s, c, o, z
    );
endinterface
`default_nettype wire

// File: rtl/addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : addsub_seq
//  Purpose  : Multi-cycle two's-complement adder/subtractor. Adds CHUNK bits
//             per clock, LSB chunk first, reusing one narrow carry chain for
//             wide operands. Optional signed saturation of the result.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-high reset
//             bus  - addsub_seq_if.slave: start/m/sat/a/b request,
//                    busy/done handshake, s result, c/o/z flags
//  Revision : 1.0 - initial release
// ============================================================================
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    addsub_seq_if.slave  bus
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [WIDTH-1:0] c_sat_pos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] c_sat_neg = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // Operands shift right one chunk per RUN cycle, so the active chunk is
    // always in the low CHUNK bits. B is stored pre-inverted for subtract.
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_a_msb;   // original sign of A, needed for saturation
    logic               r_sat;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_s;
    logic               r_c;
    logic               r_o;
    logic               r_z;

    logic               w_load;
    logic               w_last;
    logic [CHUNK:0]     w_sum;
    logic               w_cin_msb;
    logic               w_ovf;
    logic [WIDTH-1:0]   w_s_shift;
    logic [WIDTH-1:0]   w_s_final;

    // A new request is accepted from IDLE or DONE, never while running.
    assign w_load = bus.start && (r_state != S_RUN);
    assign w_last = (r_cnt == CNT_W'(N - 1));

    assign w_sum = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, r_carry};

    // Carry into the top bit of this chunk recovered from the sum bit:
    // s = a ^ b ^ cin. Only meaningful on the final chunk.
    assign w_cin_msb = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_sum[CHUNK-1];
    assign w_ovf     = w_cin_msb ^ w_sum[CHUNK];

    // Result bits enter at the top and move down, so after N cycles the
    // first (LSB) chunk has reached bit 0.
    generate
        if (CHUNK == WIDTH) begin : g_single
            assign w_s_shift = w_sum[CHUNK-1:0];
        end else begin : g_multi
            assign w_s_shift = {w_sum[CHUNK-1:0], r_s[WIDTH-1:CHUNK]};
        end
    endgenerate

    assign w_s_final = (r_sat && w_ovf) ? (r_a_msb ? c_sat_neg : c_sat_pos)
                                        : w_s_shift;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  w_state_next = bus.start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_a_msb <= 1'b0;
            r_sat   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_o     <= 1'b0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_a     <= bus.a;
                r_b     <= bus.b ^ {WIDTH{bus.m}};
                r_a_msb <= bus.a[WIDTH-1];
                r_sat   <= bus.sat;
                r_carry <= bus.m;      // +1 completes the two's complement of B
                r_cnt   <= '0;
            end else if (r_state == S_RUN) begin
                r_a     <= r_a >> CHUNK;
                r_b     <= r_b >> CHUNK;
                r_carry <= w_sum[CHUNK];
                r_cnt   <= r_cnt + CNT_W'(1);
                if (w_last) begin
                    r_s <= w_s_final;
                    r_c <= w_sum[CHUNK];
                    r_o <= w_ovf;
                    r_z <= (w_s_final == '0);
                end else begin
                    r_s <= w_s_shift;
                end
            end
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.s    = r_s;
    assign bus.c    = r_c;
    assign bus.o    = r_o;
    assign bus.z    = r_z;

endmodule
`default_nettype wire

// File: tb/tb_addsub_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_addsub_seq
//  Purpose  : Self-checking bench for addsub_seq (WIDTH=16, CHUNK=4) with an
//             arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_seq;

    localparam int WIDTH   = 16;
    localparam int CHUNK   = 4;
    localparam int LAT     = WIDTH / CHUNK;
    localparam int TIMEOUT = 40;

    logic clk;
    logic rst;
    int   vec_count = 0;
    int   err_count = 0;

    addsub_seq_if #(.WIDTH(WIDTH)) bus ();

    addsub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain signed/unsigned integer arithmetic.
    function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                      input logic m, input logic sat,
                                      output logic [18:0] res);
        int          sa, sb, sr;
        int unsigned ua, ub;
        logic [15:0] s;
        logic        c, o;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        sr = m ? (sa - sb) : (sa + sb);
        c  = m ? (ua >= ub) : ((ua + ub) > 32'hFFFF);
        o  = (sr > 32767) || (sr < -32768);
        s  = sr[15:0];
        if (sat && o) s = (sr > 32767) ? 16'h7FFF : 16'h8000;
        res = {s, c, o, (s == 16'h0000)};
    endfunction

    // Issues one operation, scrambles the inputs after acceptance, and waits
    // for done. lat = edges from acceptance to done, busy_n = busy cycles.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic m, input logic sat,
                         output logic [18:0] got, output int lat, output int busy_n);
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b; bus.m = m; bus.sat = sat;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom);
        bus.m = 1'($urandom);  bus.sat = 1'($urandom);
        lat = 0; busy_n = 0;
        while (!bus.done && lat < TIMEOUT) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            lat++;
        end
        got = {bus.s, bus.c, bus.o, bus.z};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.m = 1'b0; bus.sat = 1'b0;
        #1;
        vec_count++;
        if ({bus.busy, bus.done, bus.s, bus.c, bus.o, bus.z} !== 21'd0) begin
            err_count++;
            $display("FAIL reset_state: got %h expected 0",
                     {bus.busy, bus.done, bus.s, bus.c, bus.o, bus.z});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [15:0] a, b;
        logic        m, sat;
        logic [18:0] exp;  // {s, c, o, z}
    } vec_t;

    task automatic test_directed();
        vec_t        tbl[7];
        logic [18:0] got;
        int          lat, busy_n;
        tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, {16'h2233, 1'b0, 1'b0, 1'b0}};
        tbl[1] = '{16'h0005, 16'h0007, 1'b1, 1'b0, {16'hFFFE, 1'b0, 1'b0, 1'b0}};
        tbl[2] = '{16'h1234, 16'h1234, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1}};
        tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0}};
        tbl[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b0, 1'b1, 1'b0}};
        tbl[5] = '{16'h8000, 16'h0001, 1'b1, 1'b1, {16'h8000, 1'b1, 1'b1, 1'b0}};
        tbl[6] = '{16'h8000, 16'h0001, 1'b1, 1'b0, {16'h7FFF, 1'b1, 1'b1, 1'b0}};
        for (int i = 0; i < 7; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].m, tbl[i].sat, got, lat, busy_n);
            vec_count++;
            if (got !== tbl[i].exp) begin
                err_count++;
                $display("FAIL directed_%0d: got {s,c,o,z}=%h expected %h", i, got, tbl[i].exp);
            end
            vec_count++;
            if (lat !== LAT || busy_n !== LAT || bus.busy !== 1'b0) begin
                err_count++;
                $display("FAIL directed_timing_%0d: got lat=%0d busy_cycles=%0d busy_at_done=%b expected %0d/%0d/0",
                         i, lat, busy_n, bus.busy, LAT, LAT);
            end
        end
        @(negedge clk);
        vec_count++;
        if (bus.done !== 1'b0 || bus.s !== 16'h7FFF) begin
            err_count++;
            $display("FAIL done_pulse_hold: got done=%b s=%h expected done=0 s=7fff", bus.done, bus.s);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic        m, sat;
        logic [18:0] got, exp;
        int          lat, busy_n;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            if (i % 8 == 0) a = 16'h8000 | 16'($urandom_range(0, 3));
            if (i % 8 == 1) a = 16'h7FF0 | 16'($urandom_range(0, 15));
            m = 1'($urandom); sat = 1'($urandom);
            ref_model(a, b, m, sat, exp);
            do_op(a, b, m, sat, got, lat, busy_n);
            vec_count++;
            if (got !== exp || lat !== LAT) begin
                err_count++;
                $display("FAIL random_%0d a=%h b=%h m=%b sat=%b: got {s,c,o,z}=%h lat=%0d expected %h lat=%0d",
                         i, a, b, m, sat, got, lat, exp, LAT);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [18:0] exp;
        int          dones;
        ref_model(16'h4321, 16'h1111, 1'b0, 1'b0, exp);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h4321; bus.b = 16'h1111; bus.m = 1'b0; bus.sat = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.m = 1'b1; bus.sat = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                vec_count++;
                if ({bus.s, bus.c, bus.o, bus.z} !== exp) begin
                    err_count++;
                    $display("FAIL ignore_start_result: got %h expected %h",
                             {bus.s, bus.c, bus.o, bus.z}, exp);
                end
            end
        end
        vec_count++;
        if (dones !== 1) begin
            err_count++;
            $display("FAIL ignore_start_dones: got %0d expected 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        logic [18:0] got, exp1, exp2;
        int          lat, busy_n;
        ref_model(16'h0F0F, 16'h00F1, 1'b0, 1'b0, exp1);
        ref_model(16'h1000, 16'h2000, 1'b1, 1'b0, exp2);
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, got, lat, busy_n);
        bus.start = 1'b1; bus.a = 16'h1000; bus.b = 16'h2000; bus.m = 1'b1; bus.sat = 1'b0;
        vec_count++;
        if (got !== exp1 || lat !== LAT) begin
            err_count++;
            $display("FAIL b2b_first: got %h lat=%0d expected %h lat=%0d", got, lat, exp1, LAT);
        end
        @(negedge clk);
        bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
        vec_count++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            err_count++;
            $display("FAIL b2b_restart: got busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done);
        end
        lat = 0;
        while (!bus.done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        vec_count++;
        if ({bus.s, bus.c, bus.o, bus.z} !== exp2 || lat !== LAT) begin
            err_count++;
            $display("FAIL b2b_second: got %h lat=%0d expected %h lat=%0d",
                     {bus.s, bus.c, bus.o, bus.z}, lat, exp2, LAT);
        end
    endtask

    task automatic test_async_reset();
        logic [18:0] got, exp;
        int          lat, busy_n, dones;
        // Leave a nonzero result behind so the clear is observable.
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, got, lat, busy_n);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.m = 1'b0; bus.sat = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vec_count++;
        if ({bus.busy, bus.done, bus.s, bus.c, bus.o, bus.z} !== 21'd0) begin
            err_count++;
            $display("FAIL async_reset_clear: got %h expected 0",
                     {bus.busy, bus.done, bus.s, bus.c, bus.o, bus.z});
        end
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        vec_count++;
        if (dones !== 0) begin
            err_count++;
            $display("FAIL async_reset_no_done: got %0d active cycles expected 0", dones);
        end
        ref_model(16'hABCD, 16'h1234, 1'b1, 1'b1, exp);
        do_op(16'hABCD, 16'h1234, 1'b1, 1'b1, got, lat, busy_n);
        vec_count++;
        if (got !== exp || lat !== LAT) begin
            err_count++;
            $display("FAIL async_reset_recover: got %h lat=%0d expected %h lat=%0d", got, lat, exp, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
- Parametrised multi-cycle two's-complement adder/subtractor.
- Processes CHUNK bits per clock, LSB chunk first, so wide operands reuse one narrow carry chain.
- Start/busy/done handshake; registered sum and carry/overflow/zero flags.
- Optional signed saturation.
- Datapath building block for the team's ALU and accumulator work.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per clock cycle; N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request operation; sampled only when not busy
- m  input  1  mode: 0 = a+b, 1 = a-b
- sat  input  1  1 = saturate signed result on overflow
- a  input  WIDTH  operand A, MSB = bit WIDTH-1
- b  input  WIDTH  operand B
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse, result valid
- s  output  WIDTH  result, held until the next accepted start
- c  output  1  carry out of MSB; in subtract mode, 1 = no borrow
- o  output  1  signed overflow
- z  output  1  s == 0, evaluated after saturation

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state IDLE; busy, done, s, c, o and z all 0; internal operand and count registers cleared.
- States:
  - IDLE: start=1 at an edge latches a, latches b XOR {WIDTH{m}}, latches m and sat, sets carry = m and count = 0, then goes to RUN.
  - RUN: each edge adds chunk[count] of A and B' plus carry. Writes CHUNK result bits into the s shift/index register and updates carry, then increments count. On the edge that processes chunk N-1, goes to DONE.
  - DONE: lasts one cycle, done = 1. Next edge goes to RUN if start = 1 (back-to-back, new operands latched), otherwise to IDLE.
- Latency:
  - Start is sampled at edge E0.
  - busy = 1 from after E0 until after EN.
  - done = 1 for exactly the cycle following EN, i.e. N edges after acceptance.
  - WIDTH=16, CHUNK=4: 4 cycles.
- busy is 0 in IDLE and DONE.
- start while in RUN is ignored; no queuing.
- Operand inputs a, b, m and sat may change freely after E0 without affecting the operation.
- Flags, updated at the final RUN edge together with the last chunk:
  - c = carry out of bit WIDTH-1.
  - o = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Saturation, when latched sat=1 and o=1: s = 0111…1 if the latched a[WIDTH-1]=0, else s = 1000…0.
  - c and o report the raw (unsaturated) values.
- z is computed from the final s.
- Until the final edge, s may hold partially updated bits. s, c, o and z are architecturally valid only from done onward and stay stable until the final edge of the next operation.
- CHUNK = WIDTH is legal: N=1, done one edge after acceptance.

Test Plan (WIDTH=16, CHUNK=4):
- Add: a=0x1234, b=0x0FFF, m=0, sat=0.
  - Expect s=0x2233, c=0, o=0, z=0.
  - done exactly 4 edges after start is sampled; busy high for those 4 cycles.
- Subtract with borrow: a=0x0005, b=0x0007, m=1.
  - Expect s=0xFFFE, c=0, o=0.
- Equal subtract: a=0x1234, b=0x1234, m=1.
  - Expect s=0x0000, z=1, c=1, o=0.
- Positive overflow: a=0x7FFF, b=0x0001, m=0.
  - sat=0: expect s=0x8000, o=1, c=0.
  - sat=1: expect s=0x7FFF, o=1.
- Negative overflow: a=0x8000, b=0x0001, m=1, sat=1.
  - Expect s=0x8000, o=1, c=1.
  - Same operation with sat=0: expect s=0x7FFF.
- Handshake and reset:
  - Pulse start again during RUN: ignored, single done.
  - Hold start=1 through DONE: second operation starts immediately, done again 4 edges later.
  - Assert rst between edges mid-RUN: busy, done, s, c, o, z all go to 0 immediately and the bench sees no done; after release, a new start completes normally.
